if_id: RTL and testbench
========================

IF_ID -- requirements
Module: if_id

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port in_valid, input, 1, fetch slot valid; driven by the fetch stage chip enable.
REQ-004 SHALL have port in_pc, input, 32 (`InstAddrBus), address of fetched instruction.
REQ-005 SHALL have port in_inst, input, 32 (`InstBus), instruction word returned by instruction ROM for in_pc.
REQ-006 SHALL have port in_ready, output, 1, buffer can accept; fetch stage stalls PC when low.
REQ-007 SHALL have port flush, input, 1, jump/branch redirect; discards all buffered instructions.
REQ-008 SHALL have port id_ready, input, 1, decode stage consumes head this cycle.
REQ-009 SHALL have port out_valid, output, 1, head entry valid.
REQ-010 SHALL have port out_pc, output, 32, head entry PC.
REQ-011 SHALL have port out_inst, output, 32, head entry instruction.

Function
REQ-012 SHALL implement a 2-entry in-order FIFO of {pc, inst} with read pointer, write pointer (1 bit each, wrap 1->0) and count (0..2).
REQ-013 SHALL compute in_ready = (count != 2), derived from registered state only, never combinationally from id_ready or flush.
REQ-014 SHALL push on a rising edge when in_valid & in_ready & !flush.
REQ-015 SHALL pop on a rising edge when out_valid & id_ready & !flush.
REQ-016 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-017 SHALL give out_valid = (count != 0); out_pc/out_inst = entry at read pointer.
REQ-018 SHALL drive out_pc = `ZeroWord and out_inst = `NopInst (0x00000013) when count == 0.
REQ-019 SHALL have one-cycle latency: entry pushed at edge N appears on outputs after edge N when FIFO was empty.
REQ-020 SHALL give flush priority: on an edge with flush = 1, count and both pointers return to 0; concurrent push and pop are ignored.
REQ-021 SHALL leave entry storage unchanged by flush; only pointers/count clear.
REQ-022 SHALL never overflow or underflow: push with count 2 and pop with count 0 are impossible by REQ-013/REQ-017.

Reset
REQ-023 SHALL, while rst = 0, asynchronously clear count, pointers and storage to 0, giving in_ready = 1, out_valid = 0, out_pc = `ZeroWord, out_inst = `NopInst.
REQ-024 SHALL discard any in-flight push/pop when reset asserts mid-operation; first push allowed on first edge after rst deasserts.

Configuration
REQ-025 SHALL, with macro IF_ID_STATS_EN defined, add outputs bubble_cnt_o (32) and flush_cnt_o (32).
REQ-026 SHALL increment bubble_cnt_o on each edge where out_valid = 0 and flush = 0; flush_cnt_o on each edge where flush = 1; both saturate at 0xFFFFFFFF and reset to 0.
REQ-027 SHALL, without IF_ID_STATS_EN, omit both ports and counter logic entirely; FIFO behaviour identical.

Structure
REQ-028 SHALL take `InstAddrBus, `InstBus, `ZeroWord, `NopInst and `IfIdDepth (=2) from the shared define.v package; no local literals for these.
REQ-029 SHALL place storage and pointer logic in one sub-module if_id_fifo2; if_id instantiates it and holds push/pop/flush qualification and stats counters.

Verification
REQ-030 SHALL cover: reset release, in_valid=1, pc=0x0/0x4, id_ready=1 -> out_pc 0x0 then 0x4, one cycle behind input, in_ready stays 1.
REQ-031 SHALL cover: id_ready=0, push pc 0x8, 0xC -> count 2, in_ready=0, third input 0x10 not accepted; id_ready=1 -> pops 0x8, 0xC in order.
REQ-032 SHALL cover: count 2, flush=1 with id_ready=1 and in_valid=1 -> next cycle out_valid=0, out_inst=0x00000013, in_ready=1, nothing popped or pushed.
REQ-033 SHALL cover: count 1, simultaneous push 0x20 and pop -> count remains 1, head becomes 0x20; pointer wrap 1->0 exercised over 4 consecutive push/pop cycles.
REQ-034 SHALL cover: rst pulled low mid-stream with count 2 -> outputs immediately (without clock edge) return to reset values of REQ-023.
REQ-035 SHALL cover (IF_ID_STATS_EN): 3 empty cycles and 2 flush cycles -> bubble_cnt_o = 3, flush_cnt_o = 2; counter forced to 0xFFFFFFFF holds on further increment.

Source files
------------

// File: rtl/if_id_pkg.sv
// -----------------------------------------------------------------------------
// if_id_pkg
// Shared bus widths and constants for the IF/ID pipeline buffer.
//   InstAddrBus / InstBus : instruction address / instruction word widths
//   ZeroWord              : value shown on out_pc when the buffer is empty
//   NopInst               : value shown on out_inst when the buffer is empty
//   IfIdDepth             : number of buffered fetch slots
// -----------------------------------------------------------------------------
package if_id_pkg;

   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned InstBus     = 32;
   localparam int unsigned IfIdDepth   = 2;
   localparam int unsigned CntW        = 2;   // holds 0..IfIdDepth

   localparam logic [InstAddrBus-1:0] ZeroWord = '0;
   localparam logic [InstBus-1:0]     NopInst  = 32'h0000_0013;  // addi x0,x0,0

   localparam logic [CntW-1:0] CntFull  = CntW'(IfIdDepth);
   localparam logic [CntW-1:0] CntEmpty = '0;

endpackage : if_id_pkg

// File: rtl/if_id_fifo2.sv
// -----------------------------------------------------------------------------
// if_id_fifo2
// Two-entry in-order storage of {pc, inst} with 1-bit read/write pointers and
// an occupancy count. Push/pop arrive already qualified by the parent; flush
// has priority and clears pointers and count but leaves storage untouched.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   push_i, pop_i         : qualified write / read strobes
//   flush_i               : discard all entries
//   wr_pc_i, wr_inst_i    : entry written on push
//   rd_pc_o, rd_inst_o    : entry at the read pointer (raw storage)
//   count_o               : occupancy 0..2
// -----------------------------------------------------------------------------
module if_id_fifo2
   import if_id_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [InstAddrBus-1:0] wr_pc_i,
   input  logic [InstBus-1:0]     wr_inst_i,
   output logic [InstAddrBus-1:0] rd_pc_o,
   output logic [InstBus-1:0]     rd_inst_o,
   output logic [CntW-1:0]        count_o
);

   logic [InstAddrBus-1:0] pc_q   [IfIdDepth];
   logic [InstBus-1:0]     inst_q [IfIdDepth];
   logic                   rptr_q, rptr_d;
   logic                   wptr_q, wptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   do_push, do_pop;

   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i  & ~flush_i;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush_i) begin
         rptr_d  = 1'b0;
         wptr_d  = 1'b0;
         count_d = CntEmpty;
      end else begin
         // 1-bit pointers wrap 1->0 naturally on increment
         if (do_push) wptr_d = ~wptr_q;
         if (do_pop)  rptr_d = ~rptr_q;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;   // idle, or push+pop cancel out
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr_q  <= 1'b0;
         wptr_q  <= 1'b0;
         count_q <= CntEmpty;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Storage is only written by a push; flush deliberately does not touch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IfIdDepth; i++) begin
            pc_q[i]   <= ZeroWord;
            inst_q[i] <= '0;
         end
      end else if (do_push) begin
         pc_q[wptr_q]   <= wr_pc_i;
         inst_q[wptr_q] <= wr_inst_i;
      end
   end

   assign rd_pc_o   = pc_q[rptr_q];
   assign rd_inst_o = inst_q[rptr_q];
   assign count_o   = count_q;

endmodule : if_id_fifo2

// File: rtl/if_id.sv
// -----------------------------------------------------------------------------
// if_id
// IF/ID pipeline buffer: a 2-deep FIFO between fetch and decode.
// Handshake: an entry moves on a rising edge when valid and ready are both
// high in the same cycle (push: in_valid & in_ready; pop: out_valid &
// id_ready). in_ready depends only on registered occupancy, never on id_ready
// or flush. flush wins over both push and pop on the same edge.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   in_valid, in_pc, in_inst: fetch slot from the fetch stage
//   in_ready                : buffer has room (fetch stalls PC when low)
//   flush                   : branch/jump redirect, drops all entries
//   id_ready                : decode consumes the head this cycle
//   out_valid, out_pc,
//   out_inst                : head entry; ZeroWord / NopInst when empty
//   bubble_cnt_o, flush_cnt_o (only with IF_ID_STATS_EN defined):
//                             saturating empty-cycle and flush-cycle counters
// Optional feature macro: IF_ID_STATS_EN
// -----------------------------------------------------------------------------
module if_id
   import if_id_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [InstAddrBus-1:0] in_pc,
   input  logic [InstBus-1:0]     in_inst,
   output logic                   in_ready,
   input  logic                   flush,
   input  logic                   id_ready,
   output logic                   out_valid,
   output logic [InstAddrBus-1:0] out_pc,
   output logic [InstBus-1:0]     out_inst
`ifdef IF_ID_STATS_EN
   ,
   output logic [31:0]            bubble_cnt_o,
   output logic [31:0]            flush_cnt_o
`endif
);

   logic [CntW-1:0]        count;
   logic [InstAddrBus-1:0] head_pc;
   logic [InstBus-1:0]     head_inst;
   logic                   push, pop;

   assign in_ready  = (count != CntFull);
   assign out_valid = (count != CntEmpty);

   assign push = in_valid  & in_ready & ~flush;
   assign pop  = out_valid & id_ready & ~flush;

   if_id_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push_i    (push),
      .pop_i     (pop),
      .flush_i   (flush),
      .wr_pc_i   (in_pc),
      .wr_inst_i (in_inst),
      .rd_pc_o   (head_pc),
      .rd_inst_o (head_inst),
      .count_o   (count)
   );

   // Stale storage is masked so decode sees a NOP bubble when empty.
   assign out_pc   = out_valid ? head_pc   : ZeroWord;
   assign out_inst = out_valid ? head_inst : NopInst;

`ifdef IF_ID_STATS_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] flush_cnt_q,  flush_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (!out_valid && !flush && (bubble_cnt_q != 32'hFFFF_FFFF))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF))
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
   assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule : if_id

// File: tb/tb_if_id.sv
// -----------------------------------------------------------------------------
// tb_if_id
// Directed bench for if_id. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_if_id;
   import if_id_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        in_ready;
   logic        flush;
   logic        id_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
`ifdef IF_ID_STATS_EN
   logic [31:0] bubble_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   if_id dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_ready  (in_ready),
      .flush     (flush),
      .id_ready  (id_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_inst  (out_inst)
`ifdef IF_ID_STATS_EN
      ,
      .bubble_cnt_o (bubble_cnt_o),
      .flush_cnt_o  (flush_cnt_o)
`endif
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
      in_valid = v;
      in_pc    = pc;
      in_inst  = pc ^ 32'hA5A5_0000;
      id_ready = rdy;
      flush    = fl;
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag);
      if (exp_q.size() == 0) begin
         chk({tag, "_valid"}, 32'(out_valid), 32'd0);
         chk({tag, "_inst"},  out_inst, 32'h0000_0013);
         chk({tag, "_pc"},    out_pc,   32'h0);
      end else begin
         chk({tag, "_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_pc"},    out_pc,   exp_q[0]);
         chk({tag, "_inst"},  out_inst, exp_q[0] ^ 32'hA5A5_0000);
      end
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc",    out_pc,         32'h0);
      chk("rst_out_inst",  out_inst,       32'h0000_0013);
      tick(); tick();
      #2 rst = 1'b1;

`ifdef IF_ID_STATS_EN
      // three idle empty edges, then two flush edges
      tick(); tick(); tick();
      chk("bubble_3", bubble_cnt_o, 32'd3);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      tick(); tick();
      chk("flush_2",        flush_cnt_o,  32'd2);
      chk("bubble_hold_3",  bubble_cnt_o, 32'd3);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
`endif

      // streaming: 0x0 then 0x4, one cycle behind input
      drive(1'b1, 32'h0, 1'b1, 1'b0);
      tick(); exp_q.push_back(32'h0);
      chk_head("s0");
      chk("s0_in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 32'h4, 1'b1, 1'b0);
      tick(); void'(exp_q.pop_front()); exp_q.push_back(32'h4);
      chk_head("s4");
      chk("s4_in_ready", 32'(in_ready), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick(); void'(exp_q.pop_front());
      chk_head("s_drain");

      // fill to 2, third push refused, then drain in order
      drive(1'b1, 32'h8, 1'b0, 1'b0);
      tick(); exp_q.push_back(32'h8);
      drive(1'b1, 32'hC, 1'b0, 1'b0);
      tick(); exp_q.push_back(32'hC);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk_head("full_head");
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      tick();
      chk("full_refuse_in_ready", 32'(in_ready), 32'd0);
      chk_head("full_refuse_head");
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick(); void'(exp_q.pop_front());
      chk_head("pop_8");
      chk("pop_8_in_ready", 32'(in_ready), 32'd1);
      tick(); void'(exp_q.pop_front());
      chk_head("pop_c");

      // flush while full with pop and push requested
      drive(1'b1, 32'h40, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h44, 1'b0, 1'b0);
      tick();
      chk("pre_flush_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 32'h48, 1'b1, 1'b1);
      tick();
      chk_head("flush");
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      chk_head("flush_after");

      // count 1 with simultaneous push/pop; pointers wrap repeatedly
      drive(1'b1, 32'h1C, 1'b0, 1'b0);
      tick(); exp_q.push_back(32'h1C);
      chk_head("pp_seed");
      drive(1'b1, 32'h20, 1'b1, 1'b0);
      tick(); void'(exp_q.pop_front()); exp_q.push_back(32'h20);
      chk_head("pp_20");
      chk("pp_20_in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h24 + 32'(4 * k), 1'b1, 1'b0);
         tick(); void'(exp_q.pop_front()); exp_q.push_back(32'h24 + 32'(4 * k));
         chk_head($sformatf("pp_wrap%0d", k));
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick(); void'(exp_q.pop_front());
      chk_head("pp_drain");

      // asynchronous reset while full
      drive(1'b1, 32'h50, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h54, 1'b0, 1'b0);
      tick();
      chk("arst_pre_valid", 32'(out_valid), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_pc",    out_pc,         32'h0);
      chk("arst_out_inst",  out_inst,       32'h0000_0013);
      #2 rst = 1'b1;
      drive(1'b1, 32'h60, 1'b0, 1'b0);
      tick(); exp_q.push_back(32'h60);
      chk_head("post_rst_push");
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick(); void'(exp_q.pop_front());
      chk_head("post_rst_pop");

`ifdef IF_ID_STATS_EN
      // saturation: counter pinned at all-ones must not wrap
      force dut.bubble_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.bubble_cnt_q;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("bubble_sat", bubble_cnt_o, 32'hFFFF_FFFF);
`endif

      // ---------------- final report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_if_id
